// File: rtl/seq_bit_gen_if.sv
// seq_bit_gen_if: pattern load/handshake and serial output bundle for seq_bit_gen.
// Optional SEQ_BIT_GEN_REPEAT_EN adds the Repeat/Stop controls.
interface seq_bit_gen_if #(
    parameter int unsigned MAX_LEN = 8
);
    logic [MAX_LEN-1:0] Pattern;
    logic [3:0]         Len;
    logic               Start;
`ifdef SEQ_BIT_GEN_REPEAT_EN
    logic               Repeat;
    logic               Stop;
`endif
    logic               Ready;
    logic               w;
    logic               Valid;
    logic               Done;
    logic               Err;
    logic [1:0]         CurState;

    // Client side: loads patterns, observes the stream.
    modport master (
`ifdef SEQ_BIT_GEN_REPEAT_EN
        output Repeat,
        output Stop,
`endif
        output Pattern,
        output Len,
        output Start,
        input  Ready,
        input  w,
        input  Valid,
        input  Done,
        input  Err,
        input  CurState
    );

    // Generator side.
    modport slave (
`ifdef SEQ_BIT_GEN_REPEAT_EN
        input  Repeat,
        input  Stop,
`endif
        input  Pattern,
        input  Len,
        input  Start,
        output Ready,
        output w,
        output Valid,
        output Done,
        output Err,
        output CurState
    );
endinterface

// File: rtl/seq_bit_gen.sv
// seq_bit_gen: loads a 1..MAX_LEN bit pattern on Start and shifts it out
// MSB-first on w with a Valid strobe, then a one-cycle Done pulse.
// Illegal Len gives a one-cycle Err pulse instead.
// Optional macro SEQ_BIT_GEN_REPEAT_EN: Repeat latched at Start loops the
// pattern continuously until Stop is seen.
// All outputs come straight from flops; Resetn is synchronous, active-low.
module seq_bit_gen #(
    parameter int unsigned MAX_LEN = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    seq_bit_gen_if.slave bus
);
    localparam int unsigned LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic ready_q, ready_d;
    logic w_q, w_d;
    logic valid_q, valid_d;
    logic done_q, done_d;
    logic err_q, err_d;

`ifdef SEQ_BIT_GEN_REPEAT_EN
    logic               rep_q, rep_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
`endif

    logic               len_ok_c;
    logic [LEN_W-1:0]   align_c;
    logic [MAX_LEN-1:0] aligned_c;

    // Length check and left-alignment so Pattern[Len-1] lands in the window MSB.
    always_comb begin
        len_ok_c  = (bus.Len != '0) && (bus.Len <= LEN_W'(MAX_LEN));
        align_c   = LEN_W'(MAX_LEN) - bus.Len;
        aligned_c = bus.Pattern << align_c;
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SEQ_BIT_GEN_REPEAT_EN
        rep_d   = rep_q;
        pat_d   = pat_q;
        len_d   = len_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (len_ok_c) begin
                        state_d = SEND;
                        shreg_d = aligned_c;
                        cnt_d   = bus.Len;
`ifdef SEQ_BIT_GEN_REPEAT_EN
                        rep_d   = bus.Repeat;
                        pat_d   = aligned_c;
                        len_d   = bus.Len;
`endif
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            SEND: begin
`ifdef SEQ_BIT_GEN_REPEAT_EN
                // Stop at any SEND edge cancels looping; the pass in flight still finishes.
                rep_d = rep_q & ~bus.Stop;
`endif
                if (cnt_q == LEN_W'(1)) begin
`ifdef SEQ_BIT_GEN_REPEAT_EN
                    if (rep_d) begin
                        shreg_d = pat_q;
                        cnt_d   = len_q;
                    end else begin
                        state_d = DONE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
`else
                    state_d = DONE;
                    shreg_d = '0;
                    cnt_d   = '0;
`endif
                end else begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - LEN_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == SEND);
        w_d     = valid_d & shreg_d[MAX_LEN-1];
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEQ_BIT_GEN_REPEAT_EN
            rep_q   <= 1'b0;
            pat_q   <= '0;
            len_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SEQ_BIT_GEN_REPEAT_EN
            rep_q   <= rep_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
`endif
        end
    end

    assign bus.Ready    = ready_q;
    assign bus.w        = w_q;
    assign bus.Valid    = valid_q;
    assign bus.Done     = done_q;
    assign bus.Err      = err_q;
    assign bus.CurState = 2'(state_q);

endmodule

// File: tb/tb_seq_bit_gen.sv
// tb_seq_bit_gen: directed stimulus with a per-cycle scoreboard of expected
// outputs; each expectation is pushed as its inputs are driven and popped
// just after the next rising edge.
module tb_seq_bit_gen;
    localparam int unsigned MAX_LEN = 8;

    typedef struct packed {
        logic       ready;
        logic       w;
        logic       valid;
        logic       done;
        logic       err;
        logic [1:0] state;
    } exp_t;

    localparam exp_t E_IDLE = '{ready: 1'b1, w: 1'b0, valid: 1'b0, done: 1'b0, err: 1'b0, state: 2'b00};
    localparam exp_t E_DONE = '{ready: 1'b0, w: 1'b0, valid: 1'b0, done: 1'b1, err: 1'b0, state: 2'b10};
    localparam exp_t E_ERR  = '{ready: 1'b0, w: 1'b0, valid: 1'b0, done: 1'b0, err: 1'b1, state: 2'b11};

    function automatic exp_t e_send(input logic b);
        return '{ready: 1'b0, w: b, valid: 1'b1, done: 1'b0, err: 1'b0, state: 2'b01};
    endfunction

    logic Clock;
    logic Resetn;
    int   checks;
    int   errors;
    int   cycle;
    string tag;

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  mon_e;
    exp_t  mon_o;
    string mon_t;

    seq_bit_gen_if #(.MAX_LEN(MAX_LEN)) bus ();

    seq_bit_gen #(.MAX_LEN(MAX_LEN)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Scoreboard: compare the DUT outputs just after each rising edge.
    always @(posedge Clock) begin
        #1;
        cycle = cycle + 1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            mon_o = '{ready: bus.Ready, w: bus.w, valid: bus.Valid, done: bus.Done,
                      err: bus.Err, state: bus.CurState};
            checks = checks + 1;
            assert (mon_o === mon_e) else begin
                errors = errors + 1;
                $error("FAIL %s cyc %0d: observed rdy=%b w=%b vld=%b done=%b err=%b st=%b, expected rdy=%b w=%b vld=%b done=%b err=%b st=%b",
                       mon_t, cycle, mon_o.ready, mon_o.w, mon_o.valid, mon_o.done, mon_o.err, mon_o.state,
                       mon_e.ready, mon_e.w, mon_e.valid, mon_e.done, mon_e.err, mon_e.state);
            end
        end
    end

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic cyc(input logic rst_n, input logic st, input logic [7:0] pat,
                       input logic [3:0] len, input exp_t e);
        Resetn      = rst_n;
        bus.Start   = st;
        bus.Pattern = pat;
        bus.Len     = len;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge Clock);
    endtask

    task automatic hold(input exp_t e);
        cyc(1'b1, 1'b0, bus.Pattern, bus.Len, e);
    endtask

    // One-shot pattern: bits MSB-first, then Done, then back to IDLE.
    task automatic run_pattern(input logic [7:0] pat, input int len);
        cyc(1'b1, 1'b1, pat, 4'(len), e_send(pat[len-1]));
        for (int i = len - 2; i >= 0; i--) hold(e_send(pat[i]));
        hold(E_DONE);
        hold(E_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        cycle       = 0;
        tag         = "reset";
        Resetn      = 1'b0;
        bus.Start   = 1'b0;
        bus.Pattern = '0;
        bus.Len     = '0;
`ifdef SEQ_BIT_GEN_REPEAT_EN
        bus.Repeat  = 1'b0;
        bus.Stop    = 1'b0;
`endif
        @(negedge Clock);

        // Reset wins over a pending Start.
        cyc(1'b0, 1'b1, 8'hFF, 4'd4, E_IDLE);
        cyc(1'b0, 1'b1, 8'hFF, 4'd4, E_IDLE);
        cyc(1'b1, 1'b0, 8'hFF, 4'd4, E_IDLE);

        tag = "p0D_len4";
        run_pattern(8'b0000_1101, 4);

        tag = "pA5_len8";
        run_pattern(8'hA5, 8);

        tag = "err_len0";
        cyc(1'b1, 1'b1, 8'hFF, 4'd0, E_ERR);
        hold(E_IDLE);
        tag = "err_len9";
        cyc(1'b1, 1'b1, 8'hFF, 4'd9, E_ERR);
        cyc(1'b1, 1'b0, 8'hFF, 4'd9, E_IDLE);
        tag = "err_len15";
        cyc(1'b1, 1'b1, 8'hFF, 4'd15, E_ERR);
        cyc(1'b1, 1'b0, 8'hFF, 4'd15, E_IDLE);

        // Inputs changed mid-SEND must not disturb the bits in flight.
        tag = "ignore_mid";
        cyc(1'b1, 1'b1, 8'h0F, 4'd4, e_send(1'b1));
        cyc(1'b1, 1'b1, 8'h00, 4'd2, e_send(1'b1));
        cyc(1'b1, 1'b0, 8'h00, 4'd2, e_send(1'b1));
        hold(e_send(1'b1));
        hold(E_DONE);
        hold(E_IDLE);

        // Reset while the 3rd bit is on w: abandon, no Done.
        tag = "rst_mid";
        cyc(1'b1, 1'b1, 8'hA5, 4'd8, e_send(1'b1));
        hold(e_send(1'b0));
        hold(e_send(1'b1));
        cyc(1'b0, 1'b0, 8'hA5, 4'd8, E_IDLE);
        hold(E_IDLE);
        hold(E_IDLE);
        hold(E_IDLE);

        tag = "len1_one";
        run_pattern(8'h01, 1);
        tag = "len1_zero";
        run_pattern(8'hFE, 1);

        // Start held high: next pattern accepted on the first IDLE edge.
        tag = "start_held";
        cyc(1'b1, 1'b1, 8'h02, 4'd2, e_send(1'b1));
        cyc(1'b1, 1'b1, 8'h02, 4'd2, e_send(1'b0));
        cyc(1'b1, 1'b1, 8'h02, 4'd2, E_DONE);
        cyc(1'b1, 1'b1, 8'h02, 4'd2, E_IDLE);
        cyc(1'b1, 1'b1, 8'h02, 4'd2, e_send(1'b1));
        cyc(1'b1, 1'b0, 8'h02, 4'd2, e_send(1'b0));
        hold(E_DONE);
        hold(E_IDLE);

`ifdef SEQ_BIT_GEN_REPEAT_EN
        // Looping 110 until Stop during the 2nd bit of the third pass.
        tag = "repeat";
        bus.Repeat = 1'b1;
        cyc(1'b1, 1'b1, 8'b0000_0110, 4'd3, e_send(1'b1));
        bus.Repeat = 1'b0;
        hold(e_send(1'b1));
        hold(e_send(1'b0));
        hold(e_send(1'b1));
        hold(e_send(1'b1));
        hold(e_send(1'b0));
        hold(e_send(1'b1));
        hold(e_send(1'b1));
        bus.Stop = 1'b1;
        hold(e_send(1'b0));
        bus.Stop = 1'b0;
        hold(E_DONE);
        hold(E_IDLE);
        tag = "repeat_off";
        run_pattern(8'b0000_0110, 3);
`endif

        tag = "p0D_again";
        run_pattern(8'b0000_1101, 4);

        checks = checks + 1;
        assert (exp_q.size() == 0) else begin
            errors = errors + 1;
            $error("FAIL drain: observed %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
